// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and ALU control decode.
// Valid/ready handshake for stalls; flush squashes the slot.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [15:0]   imm16,
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  input  logic [1:0]    alu_op_main,
  input  logic [5:0]    funct,
  input  logic          alu_src,
  input  logic          reg_dst,
  input  logic          reg_write,
  input  logic          ext_zero,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] in1,
  output logic [DW-1:0] in2,
  output logic [2:0]    alu_operation,
  output logic [DW-1:0] store_data,
  output logic [RW-1:0] wr_reg,
  output logic          wr_en,
  output logic          bad_op
);

  logic          accept;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic [DW-1:0] ext;
  logic [2:0]    op_nxt;
  logic          bad_nxt;
  logic [RW-1:0] wr_reg_nxt;
  logic          wr_en_nxt;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign ext = ext_zero ? {{(DW-16){1'b0}}, imm16}
                        : {{(DW-16){imm16[15]}}, imm16};

  // Forwarding muxes: EX/MEM beats MEM/WB, r0 never forwarded.
  always_comb begin
    fwd_rs = rs_data;
    fwd_rt = rt_data;
    if (exmem_reg_write && exmem_rd == rs_addr && rs_addr != '0)
      fwd_rs = exmem_result;
    else if (memwb_reg_write && memwb_rd == rs_addr && rs_addr != '0)
      fwd_rs = memwb_result;
    if (exmem_reg_write && exmem_rd == rt_addr && rt_addr != '0)
      fwd_rt = exmem_result;
    else if (memwb_reg_write && memwb_rd == rt_addr && rt_addr != '0)
      fwd_rt = memwb_result;
  end

  // ALU control decode from ALUOp and funct.
  always_comb begin
    op_nxt  = 3'd2;
    bad_nxt = 1'b0;
    unique case (alu_op_main)
      2'b00: op_nxt = 3'd2;
      2'b01: op_nxt = 3'd6;
      2'b11: op_nxt = 3'd1;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: op_nxt = 3'd2;
          6'b100010, 6'b100011: op_nxt = 3'd6;
          6'b100100:            op_nxt = 3'd0;
          6'b100101:            op_nxt = 3'd1;
          6'b101010:            op_nxt = 3'd7;
          default: begin
            op_nxt  = 3'd2;
            bad_nxt = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign wr_reg_nxt = reg_dst ? rd_addr : rt_addr;
  assign wr_en_nxt  = reg_write & !bad_nxt & (wr_reg_nxt != '0);

  // Pipeline register: flush, then capture, then bubble on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      in1           <= '0;
      in2           <= '0;
      alu_operation <= '0;
      store_data    <= '0;
      wr_reg        <= '0;
      wr_en         <= 1'b0;
      bad_op        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      bad_op    <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      in1           <= fwd_rs;
      in2           <= alu_src ? ext : fwd_rt;
      alu_operation <= op_nxt;
      store_data    <= fwd_rt;
      wr_reg        <= wr_reg_nxt;
      wr_en         <= wr_en_nxt;
      bad_op        <= bad_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
// Hand-computed vectors checked through one compare task.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm16;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [1:0]  alu_op_main;
  logic [5:0]  funct;
  logic        alu_src, reg_dst, reg_write, ext_zero;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush, out_ready, out_valid;
  logic [31:0] in1, in2, store_data;
  logic [2:0]  alu_operation;
  logic [4:0]  wr_reg;
  logic        wr_en, bad_op;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr),
    .alu_op_main(alu_op_main), .funct(funct),
    .alu_src(alu_src), .reg_dst(reg_dst),
    .reg_write(reg_write), .ext_zero(ext_zero),
    .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid),
    .in1(in1), .in2(in2),
    .alu_operation(alu_operation),
    .store_data(store_data),
    .wr_reg(wr_reg), .wr_en(wr_en),
    .bad_op(bad_op)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = 0; rs_data = 0; rt_data = 0;
    imm16 = 0; rs_addr = 0; rt_addr = 0;
    rd_addr = 0; alu_op_main = 0; funct = 0;
    alu_src = 0; reg_dst = 0; reg_write = 0;
    ext_zero = 0; exmem_reg_write = 0;
    exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0;
    memwb_result = 0; flush = 0; out_ready = 1;
  endtask

  task automatic rtype(input logic [5:0] f,
                       input logic [4:0] rd);
    in_valid = 1; alu_op_main = 2'b10;
    funct = f; reg_dst = 1; rd_addr = rd;
    reg_write = 1;
  endtask

  task automatic chk_zero(input string p);
    check({p, "_vld"}, out_valid, 0);
    check({p, "_in1"}, in1, 0);
    check({p, "_in2"}, in2, 0);
    check({p, "_op"}, alu_operation, 0);
    check({p, "_sd"}, store_data, 0);
    check({p, "_wreg"}, wr_reg, 0);
    check({p, "_wen"}, wr_en, 0);
    check({p, "_bad"}, bad_op, 0);
  endtask

  initial begin
    rst_n = 0;
    clr_in();
    step(); step();
    chk_zero("rst");
    rst_n = 1;
    step();
    check("rst_rdy", in_ready, 1);

    // R-type add, no hazard
    rtype(6'b100000, 5'd3);
    rs_data = 5; rt_data = 7; rs_addr = 1; rt_addr = 2;
    step();
    check("add_vld", out_valid, 1);
    check("add_in1", in1, 5);
    check("add_in2", in2, 7);
    check("add_op", alu_operation, 2);
    check("add_wreg", wr_reg, 3);
    check("add_wen", wr_en, 1);
    check("add_sd", store_data, 7);

    // forwarding priority
    rs_addr = 4; rs_data = 32'h99;
    exmem_reg_write = 1; exmem_rd = 4;
    exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 4;
    memwb_result = 32'h22;
    step();
    check("fwd_exmem", in1, 32'h11);
    exmem_reg_write = 0;
    step();
    check("fwd_memwb", in1, 32'h22);
    rs_addr = 0; exmem_reg_write = 1;
    exmem_rd = 0; memwb_rd = 0;
    step();
    check("fwd_r0", in1, 32'h99);

    // rt forwarding and immediate
    rs_addr = 1; rt_addr = 4; rt_data = 32'h55;
    exmem_rd = 4; memwb_rd = 4;
    alu_src = 1; imm16 = 16'hFFFE; ext_zero = 0;
    step();
    check("imm_sext", in2, 32'hFFFF_FFFE);
    check("imm_sd", store_data, 32'h11);
    ext_zero = 1;
    exmem_reg_write = 0;
    step();
    check("imm_zext", in2, 32'h0000_FFFE);
    check("imm_sd2", store_data, 32'h22);

    // ALUOp main codes
    clr_in();
    in_valid = 1; alu_op_main = 2'b01;
    step();
    check("op_sub", alu_operation, 6);
    alu_op_main = 2'b11;
    step();
    check("op_or", alu_operation, 1);
    alu_op_main = 2'b10; funct = 6'b100100;
    step();
    check("op_and", alu_operation, 0);

    // write to r0 suppressed
    clr_in();
    rtype(6'b100010, 5'd0);
    step();
    check("r0_wen", wr_en, 0);
    check("r0_op", alu_operation, 6);

    // stall then flush
    clr_in();
    rtype(6'b100101, 5'd9);
    rs_data = 32'hA; rt_data = 32'hB;
    step();
    check("stl_vld0", out_valid, 1);
    out_ready = 0; rs_data = 32'hC;
    funct = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_rdy", in_ready, 0);
      check("stl_vld", out_valid, 1);
      check("stl_in1", in1, 32'hA);
      check("stl_op", alu_operation, 1);
    end
    flush = 1;
    step();
    check("fl_vld", out_valid, 0);
    check("fl_wen", wr_en, 0);
    flush = 0; out_ready = 1;

    // bubble after a valid slot
    step();
    check("bub_vld0", out_valid, 1);
    in_valid = 0;
    step();
    check("bub_vld", out_valid, 0);
    check("bub_wen", wr_en, 0);

    // bad funct, then SLT
    clr_in();
    rtype(6'b000111, 5'd5);
    step();
    check("bad_bad", bad_op, 1);
    check("bad_wen", wr_en, 0);
    check("bad_op", alu_operation, 2);
    funct = 6'b101010;
    step();
    check("slt_op", alu_operation, 7);
    check("slt_bad", bad_op, 0);
    check("slt_wen", wr_en, 1);

    // async reset during a stall
    out_ready = 0; rs_data = 32'h77;
    step();
    check("rs_vld0", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk_zero("arst");
    #1 rst_n = 1;
    clr_in();
    step();
    check("arst_rdy", in_ready, 1);
    check("arst_vld", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the execute ALU.
- Each cycle it captures a decoded instruction and resolves operand forwarding from EX/MEM and MEM/WB.
- It also decodes the 3-bit ALU operation from the main-control ALUOp and funct, and registers in1/in2/operation for the ALU.
- A valid/ready handshake supports stalls; a flush input squashes the slot on branches.

Parameters:
- DW, 32, datapath width (in1/in2/forwarded data).
- RW, 5, register-address width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- rs_data  input  DW  register-file read of rs
- rt_data  input  DW  register-file read of rt
- imm16  input  16  instruction immediate
- rs_addr  input  RW  source register rs
- rt_addr  input  RW  source register rt
- rd_addr  input  RW  destination register for R-type
- alu_op_main  input  2  main-control ALUOp
- funct  input  6  R-type function field
- alu_src  input  1  1 = in2 takes the extended immediate
- reg_dst  input  1  1 = destination is rd, 0 = rt
- reg_write  input  1  instruction writes the register file
- ext_zero  input  1  1 = zero-extend imm16, 0 = sign-extend
- exmem_reg_write  input  1  EX/MEM forwarding source valid
- exmem_rd  input  RW  EX/MEM destination register
- exmem_result  input  DW  EX/MEM forwarding data
- memwb_reg_write  input  1  MEM/WB forwarding source valid
- memwb_rd  input  RW  MEM/WB destination register
- memwb_result  input  DW  MEM/WB forwarding data
- flush  input  1  squash the held and incoming instruction
- out_ready  input  1  EX stage accepts output
- out_valid  output  1  registered outputs hold a live instruction
- in1  output  DW  ALU operand 1
- in2  output  DW  ALU operand 2
- alu_operation  output  3  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT
- store_data  output  DW  forwarded rt value for stores
- wr_reg  output  RW  destination register
- wr_en  output  1  register write enable carried to writeback
- bad_op  output  1  unsupported funct was captured

Behaviour:
- **Reset:** rst_n low asynchronously clears every output register to 0: out_valid, in1, in2, alu_operation, store_data, wr_reg, wr_en, bad_op.
- **Handshake:**
  - in_ready = !out_valid | out_ready (combinational).
  - accept = in_valid & in_ready.
  - Output advances when out_valid & out_ready.
  - With out_valid=1 and out_ready=0, all outputs hold stable.
- **Latency:** one cycle; an accepted instruction appears on the outputs at the next rising edge.
- **Flush:** synchronous and takes priority over everything else. On a flush edge, out_valid, wr_en and bad_op are cleared regardless of in_valid/out_ready; the incoming instruction is discarded.
- **Forwarding:** evaluated combinationally at capture, per source S in {rs, rt}.
  - If exmem_reg_write & exmem_rd==S_addr & S_addr!=0, use exmem_result.
  - Else if memwb_reg_write & memwb_rd==S_addr & S_addr!=0, use memwb_result.
  - Else use the register-file data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- **Immediate:** ext = ext_zero ? {16'b0, imm16} : {{16{imm16[15]}}, imm16}.
- **Operand capture:** in1 = fwd_rs; in2 = alu_src ? ext : fwd_rt; store_data = fwd_rt always.
- **ALU control:**
  - alu_op_main 00 -> 2 (ADD).
  - alu_op_main 01 -> 6 (SUB).
  - alu_op_main 11 -> 1 (OR).
  - alu_op_main 10 decodes funct:
    - 100000 or 100001 -> 2.
    - 100010 or 100011 -> 6.
    - 100100 -> 0.
    - 100101 -> 1.
    - 101010 -> 7.
    - Any other funct: bad_op=1, alu_operation=2, wr_en forced 0.
- **Destination:** wr_reg = reg_dst ? rd_addr : rt_addr; wr_en = reg_write & !bad_op & (wr_reg!=0).
- **Bubbles:** a cycle with out_ready=1 and no accept clears out_valid and wr_en; data fields may hold their stale values.
- **Simultaneous events:** accept together with drain replaces the slot in the same edge (full throughput).
- **Reset mid-stall:** reset asserted during a stall drops the held instruction.

Test Plan:
- Reset: rst_n=0 mid-stall with out_valid=1 -> all outputs 0 immediately, before any clock edge; in_ready=1 after release.
- R-type add, no hazard: rs_data=5, rt_data=7, alu_op_main=10, funct=100000, reg_dst=1, rd=3, reg_write=1 -> next edge out_valid=1, in1=5, in2=7, alu_operation=2, wr_reg=3, wr_en=1.
- Forward priority: rs=4, exmem_rd=4 with exmem_result=0x11, memwb_rd=4 with memwb_result=0x22 -> in1=0x11; drop exmem_reg_write -> in1=0x22; rs=0 with both matching -> in1=rs_data.
- Immediate: alu_src=1, imm16=0xFFFE, ext_zero=0 -> in2=0xFFFFFFFE; ext_zero=1 -> in2=0x0000FFFE; store_data still equals the forwarded rt.
- Stall/flush: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; then flush=1 with in_valid=1 -> out_valid=0, wr_en=0 next edge.
- Bad funct 000111 with reg_write=1 -> bad_op=1, wr_en=0, alu_operation=2; funct 101010 -> alu_operation=7, bad_op=0.
